// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//
// Input-side conditioner for the board slide switches. Each raw switch bit is
// brought into the clk domain through a two-flop synchroniser. The bit is then
// debounced by its own counter: a change is accepted only after the
// synchronised level has differed from the clean level for DB_CYCLES
// consecutive cycles. One-cycle rise/fall strobes mark every accepted change.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      asynchronous, active-high reset
//   SW        in   WIDTH  raw switch levels (asynchronous, may bounce)
//   SW_CLEAN  out  WIDTH  debounced switch levels (registered)
//   SW_RISE   out  WIDTH  1-cycle strobe per bit on a clean 0->1 change
//   SW_FALL   out  WIDTH  1-cycle strobe per bit on a clean 1->0 change
//   CHANGED   out  1      1-cycle strobe, OR of all rise/fall strobes
//   LED       out  WIDTH  combinational copy of SW_CLEAN
// ---------------------------------------------------------------------------
module switch_debouncer #(
    parameter int WIDTH     = 16,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] SW_CLEAN,
    output logic [WIDTH-1:0] SW_RISE,
    output logic [WIDTH-1:0] SW_FALL,
    output logic             CHANGED,
    output logic [WIDTH-1:0] LED
);

    localparam int               CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0]            sync1_q, sync1_d;
    logic [WIDTH-1:0]            sync2_q, sync2_d;
    logic [WIDTH-1:0]            clean_q, clean_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic                        changed_q, changed_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Per channel: STABLE when the synchronised level matches the clean level
    // (counter held at zero), PENDING otherwise. A single matching cycle while
    // pending clears the counter, so any bounce restarts the full count.
    always_comb begin
        sync1_d = SW;
        sync2_d = sync1_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    clean_d[i] = sync2_q[i];
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        // Strobes are derived from the same accept decision, so CHANGED lines
        // up with SW_RISE/SW_FALL in the same cycle.
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign SW_CLEAN = clean_q;
    assign SW_RISE  = rise_q;
    assign SW_FALL  = fall_q;
    assign CHANGED  = changed_q;
    assign LED      = clean_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
//
// Directed bench for switch_debouncer with DB_CYCLES = 4, WIDTH = 16.
// Expected per-cycle outputs are queued when stimulus is applied and popped
// one entry per clock, compared 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_switch_debouncer;

    localparam int WIDTH     = 16;
    localparam int DB_CYCLES = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] SW  = 16'hFFFF;
    logic [WIDTH-1:0] SW_CLEAN;
    logic [WIDTH-1:0] SW_RISE;
    logic [WIDTH-1:0] SW_FALL;
    logic             CHANGED;
    logic [WIDTH-1:0] LED;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] clean;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
    } exp_t;

    exp_t sb[$];

    switch_debouncer #(
        .WIDTH    (WIDTH),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .SW      (SW),
        .SW_CLEAN(SW_CLEAN),
        .SW_RISE (SW_RISE),
        .SW_FALL (SW_FALL),
        .CHANGED (CHANGED),
        .LED     (LED)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_n(input int n, input logic [WIDTH-1:0] clean,
                          input logic [WIDTH-1:0] rise,
                          input logic [WIDTH-1:0] fall, input string tag);
        exp_t e;
        e.tag   = tag;
        e.clean = clean;
        e.rise  = rise;
        e.fall  = fall;
        for (int k = 0; k < n; k++) sb.push_back(e);
    endtask

    // One clock per queued entry; the loop is bounded by the queue length.
    task automatic drain();
        exp_t e;
        int   n;
        n = sb.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk({e.tag, ".clean"},   SW_CLEAN, e.clean);
            chk({e.tag, ".led"},     LED,      e.clean);
            chk({e.tag, ".rise"},    SW_RISE,  e.rise);
            chk({e.tag, ".fall"},    SW_FALL,  e.fall);
            chk({e.tag, ".changed"}, {{(WIDTH-1){1'b0}}, CHANGED},
                {{(WIDTH-1){1'b0}}, |(e.rise | e.fall)});
        end
    endtask

    // Clean level change held from here on: old level through edges 0..4,
    // accepted at edge 5 with one strobe cycle, then steady.
    task automatic apply_step(input logic [WIDTH-1:0] new_sw,
                              input logic [WIDTH-1:0] prev_clean,
                              input string tag);
        SW = new_sw;
        push_n(1 + DB_CYCLES, prev_clean, '0, '0, {tag, ".wait"});
        push_n(1, new_sw, new_sw & ~prev_clean, prev_clean & ~new_sw,
               {tag, ".accept"});
        push_n(2, new_sw, '0, '0, {tag, ".hold"});
        drain();
    endtask

    initial begin
        // Reset held with all switches high: everything stays cleared.
        push_n(3, '0, '0, '0, "reset_hold");
        drain();

        rst = 1'b0;
        SW  = '0;
        push_n(8, '0, '0, '0, "reset_release");
        drain();

        // Single clean step on bit 0.
        apply_step(16'h0001, 16'h0000, "step_b0");

        // Bit 3 high for only 3 cycles: rejected.
        SW = 16'h0009;
        push_n(3, 16'h0001, '0, '0, "bounce_b3_high");
        drain();
        SW = 16'h0001;
        push_n(8, 16'h0001, '0, '0, "bounce_b3_low");
        drain();

        // Bit 5 toggles each cycle, then settles high.
        SW = 16'h0021; push_n(1, 16'h0001, '0, '0, "toggle_b5_1"); drain();
        SW = 16'h0001; push_n(1, 16'h0001, '0, '0, "toggle_b5_2"); drain();
        SW = 16'h0021; push_n(1, 16'h0001, '0, '0, "toggle_b5_3"); drain();
        SW = 16'h0001; push_n(1, 16'h0001, '0, '0, "toggle_b5_4"); drain();
        apply_step(16'h0021, 16'h0001, "settle_b5");

        // Multi-bit falls and rises in a single cycle.
        apply_step(16'h0000, 16'h0021, "fall_b0_b5");
        apply_step(16'hA5A5, 16'h0000, "multi_rise");
        apply_step(16'h0000, 16'hA5A5, "multi_fall");

        // Reset in the middle of a pending change on bit 1.
        SW = 16'h0002;
        push_n(3, '0, '0, '0, "midcount_pre");
        drain();
        rst = 1'b1;
        push_n(2, '0, '0, '0, "midcount_rst");
        drain();
        rst = 1'b0;
        push_n(1 + DB_CYCLES, '0, '0, '0, "midcount_wait");
        push_n(1, 16'h0002, 16'h0002, '0, "midcount_accept");
        push_n(2, 16'h0002, '0, '0, "midcount_hold");
        drain();

        // Reset clears the clean level without waiting for a clock edge.
        rst = 1'b1;
        #2;
        chk("async_rst.clean", SW_CLEAN, '0);
        chk("async_rst.led",   LED,      '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        SW  = '0;
        push_n(8, '0, '0, '0, "async_rst_after");
        drain();

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_empty observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
